ro_race_counter: RTL
====================

# ro_race_counter

Upstream race stage of the ring-oscillator PUF. The block counts rising edges from two free-running ring oscillators. When either count reaches a programmed threshold, it asserts the matching `finished1`/`finished2` level, which feeds the race arbiter directly. It also provides start/busy handshaking, tie and timeout reporting, and a readback of both counts for characterisation.

## Interface
Parameters:
- `CNT_W`, 16: width of each edge counter.
- `THRESH`, 16'd1000: edge count that ends the race. Must satisfy 1 ≤ THRESH ≤ 2^CNT_W−1.
- `TMO_W`, 24: width of the timeout cycle counter.
- `TIMEOUT`, 24'hFF_FFFF: number of RUN cycles before the race is abandoned.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a race. Honoured only in IDLE or DONE.
- `ro1` in 1: ring oscillator 1 output, asynchronous to `clk`.
- `ro2` in 1: ring oscillator 2 output, asynchronous to `clk`.
- `finished1` out 1: oscillator 1 reached THRESH. Held until the next start or reset.
- `finished2` out 1: oscillator 2 reached THRESH. Held likewise.
- `tie` out 1: both oscillators reached THRESH in the same cycle.
- `timeout` out 1: TIMEOUT expired with neither oscillator finished.
- `busy` out 1: high while in RUN.
- `count1` out CNT_W: current edge count for oscillator 1.
- `count2` out CNT_W: current edge count for oscillator 2.

## Operation
- Each `roN` passes through a 2-FF synchroniser and then a rising-edge detector (a third flop plus `sync & ~prev`). This produces a one-cycle `edgeN` pulse.
- The edge detectors run continuously, including outside RUN and during reset release.
- FSM states: IDLE, RUN, DONE.
- IDLE, with `start`=1: clear both counters, the timeout counter and all flags, then go to RUN.
- RUN, each cycle:
  - `countN` increments on `edgeN`, saturating at THRESH.
  - The timeout counter increments by 1.
- RUN exits:
  - If any increment makes a counter equal THRESH, set the matching `finishedN` and go to DONE.
  - If both counters reach THRESH in the same cycle, set `finished1`, `finished2` and `tie`.
  - If the timeout counter reaches TIMEOUT−1 with no finish in that cycle, set `timeout` and go to DONE.
  - A finish in the same cycle as the timeout wins, and `timeout` stays 0.
- DONE: counters freeze, flags hold, and `start` restarts exactly as from IDLE. There is no separate clear input.
- `start` while in RUN is ignored. It is neither queued nor restarts the race.
- Counter arithmetic is unsigned CNT_W, with no wrap. The timeout counter is unsigned TMO_W, and TIMEOUT must be below 2^TMO_W.
- Frequency requirement: `roN` must toggle at no more than clk/4 for the counts to be exact. Faster oscillators undercount. This is not detected.

## Timing
- Reset (`rst_n`=0 at a clock edge) gives, at that edge:
  - state IDLE;
  - `finished1`, `finished2`, `tie`, `timeout`, `busy` = 0;
  - `count1`, `count2` = 0;
  - the timeout counter = 0.
- Edge detector flops also reset to 0.
- Reset asserted mid-RUN aborts the race immediately. No finished pulse is produced.
- `start` sampled at edge k: `busy`=1 and the counters read 0 from edge k onward. The first countable edge is one whose `edgeN` pulse is present at edge k+1.
- Latency from a rising edge of `roN` to the `countN` increment is 3–4 clk cycles (synchroniser plus edge register).
- `finishedN` rises at the same clock edge at which `countN` becomes THRESH. At that same edge `busy` falls and the state becomes DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Because `finishedN` holds as a level, the arbiter sees a stable level and gives `finished1` priority on a tie. `tie` is therefore the only indication that the decision was not clean.

## Structure
- Shared package `ro_puf_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default CNT_W, THRESH, TMO_W and TIMEOUT constants, reused by the arbiter and the response collector.
- Sub-module `ro_edge_sync` (2-FF synchroniser plus rising-edge pulse, with `clk`/`rst_n`) is instantiated once per oscillator.
- The top level contains the FSM, the two saturating counters, the timeout counter and the flag registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles while `ro1`/`ro2` toggle → all outputs 0 and state IDLE; with `start` held low after release, `busy` stays 0.
- Basic race: THRESH=8, `ro1` period 8 clk, `ro2` period 12 clk, pulse `start`:
  - `finished1`=1 when `count1`=8;
  - `count2` freezes at 5;
  - `finished2`=0, `tie`=0, `busy`=0 from the same edge.
- Tie: THRESH=4, `ro1` and `ro2` driven identically (period 8) → `finished1`=`finished2`=`tie`=1 at the same edge, and both counts equal 4.
- Timeout: TIMEOUT=20, `ro1`/`ro2` held at 0 → `timeout`=1 exactly 20 cycles after the `start` edge, with counts 0 and both finished flags 0.
- Restart and ignore: while in RUN, pulse `start` again → no effect. After DONE, pulse `start` → flags clear and counts return to 0 at that edge. Then assert `rst_n`=0 mid-race → all outputs 0 at the next edge.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types and default constants for the ring-oscillator PUF
//
// Purpose : common definitions used by the race counter, the arbiter and the
//           response collector.
// Contents: race_state_t    - race FSM state encoding (IDLE, RUN, DONE)
//           RO_CNT_W        - default edge counter width
//           RO_THRESH       - default edge count that ends a race
//           RO_TMO_W        - default timeout counter width
//           RO_TIMEOUT      - default number of RUN cycles before abandoning
package ro_puf_pkg;

    localparam int              RO_CNT_W   = 16;
    localparam logic [15:0]     RO_THRESH  = 16'd1000;
    localparam int              RO_TMO_W   = 24;
    localparam logic [23:0]     RO_TIMEOUT = 24'hFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } race_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - two-flop synchroniser with registered rising-edge pulse
//
// Purpose: brings an asynchronous oscillator output into the clk domain and
//          emits a one-cycle pulse for each rising edge seen.
// Ports  : clk    - sampling clock
//          rst_n  - synchronous active-low reset
//          din    - asynchronous input
//          pulse  - registered one-cycle pulse per synchronised rising edge
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // meta/sync form the synchroniser; prev holds the previous synchronised
    // level so a rising edge is sync & ~prev. The pulse itself is registered
    // so the downstream counter sees a clean flop output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/ro_race_counter.sv
// rtl/ro_race_counter.sv - ring-oscillator race stage: edge counters, FSM, flags
//
// Purpose: counts rising edges of two free-running oscillators after a start
//          request; the first to reach THRESH raises its finished level.
// Ports  : clk, rst_n          - clock, synchronous active-low reset
//          start               - one-cycle race request (IDLE/DONE only)
//          ro1, ro2            - asynchronous oscillator outputs
//          finished1/2         - oscillator reached THRESH (held until restart)
//          tie                 - both reached THRESH in the same cycle
//          timeout             - TIMEOUT expired with no finish
//          busy                - race in progress
//          count1/2            - current edge counts
module ro_race_counter
    import ro_puf_pkg::*;
#(
    parameter int               CNT_W   = RO_CNT_W,
    parameter logic [CNT_W-1:0] THRESH  = CNT_W'(RO_THRESH),
    parameter int               TMO_W   = RO_TMO_W,
    parameter logic [TMO_W-1:0] TIMEOUT = TMO_W'(RO_TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ro1,
    input  logic             ro2,
    output logic             finished1,
    output logic             finished2,
    output logic             tie,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2
);

    localparam logic [CNT_W-1:0] THRESH_M1 = THRESH - CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TIMEOUT - TMO_W'(1);

    race_state_t      state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             edge1;
    logic             edge2;
    logic             hit1;
    logic             hit2;
    logic             sat1;
    logic             sat2;

    ro_edge_sync u_sync1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ro1),
        .pulse (edge1)
    );

    ro_edge_sync u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ro2),
        .pulse (edge2)
    );

    // A counter below THRESH reaches it on this cycle's increment exactly
    // when it currently holds THRESH-1 and an edge arrives.
    always_comb begin
        sat1 = (count1 == THRESH);
        sat2 = (count2 == THRESH);
        hit1 = edge1 && (count1 == THRESH_M1);
        hit2 = edge2 && (count2 == THRESH_M1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            finished1 <= 1'b0;
            finished2 <= 1'b0;
            tie       <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            count1    <= '0;
            count2    <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE freezes everything; start behaves as from IDLE.
                    if (start) begin
                        state     <= ST_RUN;
                        finished1 <= 1'b0;
                        finished2 <= 1'b0;
                        tie       <= 1'b0;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                        count1    <= '0;
                        count2    <= '0;
                        tmo_cnt   <= '0;
                    end
                end

                ST_RUN: begin
                    // start is deliberately not looked at here.
                    if (edge1 && !sat1) begin
                        count1 <= count1 + CNT_W'(1);
                    end
                    if (edge2 && !sat2) begin
                        count2 <= count2 + CNT_W'(1);
                    end
                    tmo_cnt <= tmo_cnt + TMO_W'(1);

                    // A finish takes precedence over a coincident timeout.
                    if (hit1 || hit2) begin
                        finished1 <= hit1;
                        finished2 <= hit2;
                        tie       <= hit1 && hit2;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
